// File: rtl/watchdog_timer.sv
// watchdog_timer: register-programmed watchdog with a sticky expiry flag.
//
// A control write to WDOG_ADDR loads the period (reg_wdata[15:0]) and arms
// the timer; a zero period disables it. Any other register write while armed
// is a kick that reloads the countdown. The countdown decrements once per
// prescaler tick (PRESCALE sysclk cycles); reaching zero latches
// wdog_timeout, which holds until the next control write or reset.
//
// Optional feature macro: WDOG_WARN_EN
//   defined   -> wdog_warn asserts while armed with count <= period/4
//                (only for period >= 4)
//   undefined -> wdog_warn and wdog_status[28] are tied to 0
//
// state     | meaning
// ----------+---------------------------------------------------------
// DISABLED  | no period programmed (or period 0); kicks ignored
// ARMED     | counting down; kicks reload count from period
// EXPIRED   | count hit zero; wdog_timeout held, kicks ignored

module watchdog_timer #(
    parameter logic [7:0] WDOG_ADDR = 8'h03,
    parameter int         PRESCALE  = 3072
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        reg_wen,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic        wdog_timeout,
    output logic        wdog_warn,
    output logic [31:0] wdog_status
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_EXPIRED  = 2'b10
    } state_t;

    // Last prescaler value; the tick fires while the prescaler sits here.
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    state_t      state_q,   state_d;
    logic [15:0] period_q,  period_d;
    logic [15:0] count_q,   count_d;
    logic [15:0] presc_q,   presc_d;
    logic        timeout_q, timeout_d;
    logic [31:0] status_q,  status_d;
    logic        warn_bit;

    logic        ctrl_wr;
    logic        kick;
    logic        tick;
    logic [15:0] wr_period;

    // Upper write-data bits carry nothing for this block.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[31:16];

    // Decode the register strobe into control write / kick, and form the tick.
    always_comb begin
        ctrl_wr   = reg_wen && (reg_addr == WDOG_ADDR);
        kick      = reg_wen && (reg_addr != WDOG_ADDR);
        wr_period = reg_wdata[15:0];
        tick      = (state_q == ST_ARMED) && (presc_q == PS_LAST);
    end

    // Next-state logic: control write beats kick, kick beats an expiring tick.
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        count_d   = count_q;
        presc_d   = presc_q;
        timeout_d = timeout_q;

        if (ctrl_wr) begin
            presc_d   = 16'd0;
            timeout_d = 1'b0;
            if (wr_period == 16'd0) begin
                state_d = ST_DISABLED;
                count_d = 16'd0;
            end else begin
                state_d  = ST_ARMED;
                period_d = wr_period;
                count_d  = wr_period;
            end
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (kick) begin
                        count_d = period_q;
                        presc_d = 16'd0;
                    end else if (tick) begin
                        presc_d = 16'd0;
                        if (count_q <= 16'd1) begin
                            count_d   = 16'd0;
                            timeout_d = 1'b1;
                            state_d   = ST_EXPIRED;
                        end else begin
                            count_d = count_q - 16'd1;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                ST_EXPIRED: begin
                    count_d   = 16'd0;
                    presc_d   = 16'd0;
                    timeout_d = 1'b1;
                end
                ST_DISABLED: begin
                    presc_d = 16'd0;
                end
                default: begin
                    state_d   = ST_DISABLED;
                    count_d   = 16'd0;
                    presc_d   = 16'd0;
                    timeout_d = 1'b0;
                end
            endcase
        end
    end

`ifdef WDOG_WARN_EN
    logic warn_q, warn_d;

    // Early warning evaluated on the next-state values so it moves with count.
    always_comb begin
        warn_d = (state_d == ST_ARMED) && (period_d >= 16'd4) &&
                 (count_d <= (period_d >> 2));
    end

    // Warning flop.
    always_ff @(posedge sysclk) begin
        if (reset) warn_q <= 1'b0;
        else       warn_q <= warn_d;
    end

    assign warn_bit = warn_q;
`else
    assign warn_bit = 1'b0;
`endif

    // Status word snapshots the registered state, so it lags by one cycle.
    always_comb begin
        status_d = {timeout_q, state_q, warn_bit, 12'b0, count_q};
    end

    // State and output registers; reset overrides any coincident activity.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_DISABLED;
            period_q  <= 16'd0;
            count_q   <= 16'd0;
            presc_q   <= 16'd0;
            timeout_q <= 1'b0;
            status_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            timeout_q <= timeout_d;
            status_q  <= status_d;
        end
    end

    assign wdog_timeout = timeout_q;
    assign wdog_warn    = warn_bit;
    assign wdog_status  = status_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Bench for watchdog_timer with PRESCALE=4 and the default register address.
module tb_watchdog_timer;

    localparam int         PS   = 4;
    localparam logic [7:0] CTRL = 8'h03;
    localparam logic [7:0] KICK = 8'h10;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_wen = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [31:0] reg_wdata = 32'h0;
    logic        wdog_timeout;
    logic        wdog_warn;
    logic [31:0] wdog_status;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    watchdog_timer #(.WDOG_ADDR(CTRL), .PRESCALE(PS)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .reg_wen      (reg_wen),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .wdog_timeout (wdog_timeout),
        .wdog_warn    (wdog_warn),
        .wdog_status  (wdog_status)
    );

    always #5 sysclk = ~sysclk;

    // Inputs change #1 after a rising edge; outputs are read at that point too.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        reg_wen   = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        step(1);
        reg_wen   = 1'b0;
        reg_wdata = 32'h0;
    endtask

    task automatic test_reset;
        int e;
        reset = 1'b1;
        bus_write(CTRL, 32'd5);
        step(1);
        reset = 1'b0;
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({31'd0, wdog_timeout} !== e) begin
            n_fail++;
            $display("FAIL reset_timeout: got %0b want %0d", wdog_timeout, e);
        end
        n_cmp++;
        if (wdog_warn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_warn: got %0b want 0", wdog_warn);
        end
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e)) begin
            n_fail++;
            $display("FAIL reset_status: got %h want %h", wdog_status, 32'(e));
        end
    endtask

    task automatic test_expiry;
        int n, e;
        bus_write(CTRL, 32'd5);
        exp_q.push_back(5 * PS);
        n = 0;
        while (wdog_timeout !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL expiry_latency: got %0d cycles want %0d", n, e);
        end
        step(1);
        exp_q.push_back(32'h C000_0000);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e)) begin
            n_fail++;
            $display("FAIL expiry_status: got %h want %h", wdog_status, 32'(e));
        end
    endtask

    task automatic test_kicks;
        int min_cnt, seen, e;
        bus_write(CTRL, 32'd5);
        exp_q.push_back(0);
        exp_q.push_back(3);
        min_cnt = 65535;
        seen = 0;
        for (int c = 1; c <= 200; c++) begin
            reg_wen  = (c % 12 == 0);
            reg_addr = KICK;
            step(1);
            reg_wen = 1'b0;
            if (wdog_timeout) seen = 1;
            if (c >= 2 && int'(wdog_status[15:0]) < min_cnt) min_cnt = int'(wdog_status[15:0]);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (seen !== e) begin
            n_fail++;
            $display("FAIL kicks_timeout: got %0d want %0d", seen, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (min_cnt !== e) begin
            n_fail++;
            $display("FAIL kicks_min_count: got %0d want %0d", min_cnt, e);
        end
    endtask

    task automatic test_kick_on_tick;
        int n, e;
        bus_write(CTRL, 32'd5);
        step(5 * PS - 1);
        exp_q.push_back(0);
        bus_write(KICK, 32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({31'd0, wdog_timeout} !== e) begin
            n_fail++;
            $display("FAIL kick_on_tick_timeout: got %0b want %0d", wdog_timeout, e);
        end
        exp_q.push_back(5 * PS);
        n = 0;
        while (wdog_timeout !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL kick_on_tick_latency: got %0d cycles want %0d", n, e);
        end
    endtask

    task automatic test_expired;
        int e;
        bus_write(KICK, 32'h0);
        step(1);
        exp_q.push_back(32'h C000_0000);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e) || wdog_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL expired_kick: got status %h timeout %0b want %h/1", wdog_status, wdog_timeout, 32'(e));
        end
        bus_write(CTRL, 32'd0);
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({31'd0, wdog_timeout} !== e) begin
            n_fail++;
            $display("FAIL disable_timeout: got %0b want %0d", wdog_timeout, e);
        end
        bus_write(KICK, 32'h0);
        step(2);
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e)) begin
            n_fail++;
            $display("FAIL disabled_status: got %h want %h", wdog_status, 32'(e));
        end
        bus_write(CTRL, 32'd8);
        exp_q.push_back(32'h 2000_0008);
        step(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e)) begin
            n_fail++;
            $display("FAIL rearm_status: got %h want %h", wdog_status, 32'(e));
        end
    endtask

    task automatic test_warn;
        int n, e;
        bus_write(CTRL, 32'd8);
`ifdef WDOG_WARN_EN
        exp_q.push_back(24);
        n = 0;
        while (wdog_warn !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL warn_rise: got %0d cycles want %0d", n, e);
        end
        step(1);
        n_cmp++;
        if (wdog_status[28] !== 1'b1 || wdog_status[15:0] !== 16'd2) begin
            n_fail++;
            $display("FAIL warn_status: got %h want bit28=1 count=2", wdog_status);
        end
        bus_write(KICK, 32'h0);
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({31'd0, wdog_warn} !== e) begin
            n_fail++;
            $display("FAIL warn_clear: got %0b want %0d", wdog_warn, e);
        end
`else
        exp_q.push_back(0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (wdog_warn !== 1'b0 || wdog_status[28] !== 1'b0) n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_fail++;
            $display("FAIL warn_tied: got %0d cycles with warn set want %0d", n, e);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int e;
        bus_write(CTRL, 32'd5);
        step(2 * PS);
        n_cmp++;
        if (wdog_status[30:29] !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_armed: got state %b want 01", wdog_status[30:29]);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e) || wdog_timeout !== 1'b0 || wdog_warn !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got status %h timeout %0b warn %0b want all 0",
                     wdog_status, wdog_timeout, wdog_warn);
        end
        bus_write(KICK, 32'h0);
        step(3);
        bus_write(KICK, 32'h0);
        step(2);
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (wdog_status !== 32'(e)) begin
            n_fail++;
            $display("FAIL mid_kick_ignored: got %h want %h", wdog_status, 32'(e));
        end
    endtask

    initial begin
        step(1);
        test_reset;
        test_expiry;
        test_kicks;
        test_kick_on_tick;
        test_expired;
        test_warn;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL run_timeout: got no completion want completion");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/watchdog_timer.md
WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 SHALL have parameter WDOG_ADDR, default 8'h03: register address of the watchdog period/control quadlet.
REQ-002 SHALL have parameter PRESCALE, default 3072: sysclk cycles per watchdog tick (16 kHz at 49.152 MHz); legal range 2..65535.
REQ-003 SHALL have port sysclk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port reg_wen, input, 1: one-cycle quadlet write strobe from the phy-link interface.
REQ-006 SHALL have port reg_addr, input, 8: write address, qualified by reg_wen.
REQ-007 SHALL have port reg_wdata, input, 32: write data; bits [15:0] are the period in ticks.
REQ-008 SHALL have port wdog_timeout, output, 1: sticky expiry flag; drives amplifier disable.
REQ-009 SHALL have port wdog_warn, output, 1: early-warning flag (see Configuration).
REQ-010 SHALL have port wdog_status, output, 32: readback {wdog_timeout, state[1:0], wdog_warn, 12'b0, count[15:0]}.

Function
REQ-011 SHALL implement states DISABLED, ARMED, EXPIRED; state encoding DISABLED=2'b00, ARMED=2'b01, EXPIRED=2'b10.
REQ-012 SHALL define a control write as reg_wen=1 with reg_addr==WDOG_ADDR; a kick as reg_wen=1 with any other address.
REQ-013 SHALL, on a control write with reg_wdata[15:0]==0 in any state, enter DISABLED, clear count and wdog_timeout.
REQ-014 SHALL, on a control write with reg_wdata[15:0]=P!=0 in any state, store P as period, load count=P, clear prescaler and wdog_timeout, enter ARMED.
REQ-015 SHALL, on a kick in ARMED, reload count=period and clear prescaler; kicks in DISABLED or EXPIRED are ignored.
REQ-016 SHALL run a prescaler 0..PRESCALE-1 only in ARMED, producing a one-cycle tick when it equals PRESCALE-1, then wrapping to 0.
REQ-017 SHALL decrement count on each tick in ARMED; a tick with count==1 sets count=0, wdog_timeout=1, state EXPIRED.
REQ-018 SHALL assert wdog_timeout exactly period*PRESCALE cycles after the edge that sampled the last load/kick, absent further kicks.
REQ-019 SHALL give a kick or control write priority over a coincident expiring tick (no expiry that cycle).
REQ-020 SHALL hold wdog_timeout=1 and count=0 in EXPIRED until a control write or reset.
REQ-021 SHALL register all outputs; wdog_status reflects state one cycle after each update.

Reset
REQ-022 SHALL on reset=1 set state DISABLED, period=0, count=0, prescaler=0, wdog_timeout=0, wdog_warn=0, wdog_status=0.
REQ-023 SHALL let reset override any coincident write, kick or tick, including mid-countdown and in EXPIRED.

Configuration
REQ-024 SHALL, with macro WDOG_WARN_EN defined, assert wdog_warn while ARMED and count <= period>>2 (period>=4), deasserting on reload; for period<4 wdog_warn stays 0.
REQ-025 SHALL, with WDOG_WARN_EN undefined, tie wdog_warn and wdog_status[28] to 0 and synthesize no comparison logic.

Verification (PRESCALE=4)
REQ-026 SHALL verify: reset, control write P=5, no kicks -> wdog_timeout rises exactly 20 cycles after write, state EXPIRED, count 0.
REQ-027 SHALL verify: P=5, kick (addr 8'h10) every 12 cycles for 200 cycles -> wdog_timeout stays 0, count never below 3.
REQ-028 SHALL verify: kick on the exact cycle of the expiring tick -> no timeout; timeout 20 cycles after that kick.
REQ-029 SHALL verify: in EXPIRED, kick -> stays 1; control write 0 -> DISABLED, wdog_timeout 0; control write P=8 -> ARMED, count 8.
REQ-030 SHALL verify: WDOG_WARN_EN defined, P=8 -> wdog_warn rises when count reaches 2 (cycle 24), clears on kick; undefined -> wdog_warn constant 0.
REQ-031 SHALL verify: reset asserted mid-countdown (count 3) -> next cycle all outputs 0, state DISABLED, subsequent kicks ignored.
